vec_engine_scheduler: RTL

- Shares one elementwise vector engine (ReLU-class, WorkingRegs lanes of signed 8-bit) between NumReq layer requesters.
- Grants the engine round-robin for one whole vector at a time and muxes the winner's chunk stream into the engine.
- Counts result chunks back out and pulses a per-requester done.
- Sits between the per-layer chunk FIFOs and the shared engine instance.

---
 rtl/vec_engine_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vec_engine_scheduler.sv
// rtl/vec_engine_scheduler.sv - round-robin owner of the shared vector engine; VEC_SCHED_WATCHDOG_EN adds a stall watchdog
module vec_engine_scheduler #(
    parameter int NumReq        = 4,
    parameter int InVecLength   = 64,
    parameter int WorkingRegs   = 4,
    parameter int TimeoutCycles = 256
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [NumReq-1:0]               req_in,
    input  logic [NumReq-1:0]               src_valid_in,
    input  logic [NumReq*WorkingRegs*8-1:0] src_data_in,
    output logic [NumReq-1:0]               src_pop_out,
    output logic [WorkingRegs*8-1:0]        eng_data_out,
    output logic                            eng_valid_out,
    input  logic                            eng_ready_in,
    input  logic                            eng_res_valid_in,
    output logic [NumReq-1:0]               grant_out,
    output logic [$clog2(NumReq)-1:0]       grant_id_out,
    output logic                            busy_out,
    output logic [NumReq-1:0]               done_out,
    output logic                            err_out
);

    localparam int Chunks = InVecLength / WorkingRegs;
    localparam int IdW    = $clog2(NumReq);
    localparam int CntW   = $clog2(Chunks + 1);
    localparam int ChunkW = WorkingRegs * 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CntW-1:0] in_cnt;
    logic [CntW-1:0] out_cnt;
    logic [CntW-1:0] in_cnt_nxt;
    logic [CntW-1:0] out_cnt_nxt;
    logic [IdW-1:0]  rr_ptr;
    logic [IdW-1:0]  arb_id;
    logic [IdW-1:0]  arb_cand;
    logic            arb_found;
    logic            pop;
    logic            res_over;
    logic            vec_done;
    logic            wd_timeout;

    // Round-robin search starting just after the last served requester
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        arb_cand  = '0;
        for (int k = 1; k <= NumReq; k++) begin
            arb_cand = IdW'((int'(rr_ptr) + k) % NumReq);
            if (!arb_found && req_in[arb_cand]) begin
                arb_found = 1'b1;
                arb_id    = arb_cand;
            end
        end
    end

    // Next counter values; a result may never outrun the chunks already sent
    always_comb begin
        pop         = |src_pop_out;
        in_cnt_nxt  = in_cnt;
        out_cnt_nxt = out_cnt;
        res_over    = 1'b0;
        if (pop) begin
            in_cnt_nxt = in_cnt + CntW'(1);
        end
        if (eng_res_valid_in && state != IDLE) begin
            if (out_cnt < in_cnt_nxt) begin
                out_cnt_nxt = out_cnt + CntW'(1);
            end else begin
                res_over = 1'b1;
            end
        end
        vec_done = (state != IDLE) && (in_cnt_nxt == CntW'(Chunks))
                   && (out_cnt_nxt == CntW'(Chunks));
    end

`ifdef VEC_SCHED_WATCHDOG_EN
    localparam int WdW = $clog2(TimeoutCycles + 1);
    logic [WdW-1:0] wd_cnt;

    assign wd_timeout = (state != IDLE) && (wd_cnt == WdW'(TimeoutCycles))
                        && !pop && !eng_res_valid_in;

    // Idle-cycle counter, restarted by any forward progress of the owner
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wd_cnt <= '0;
        end else if (state == IDLE || pop || eng_res_valid_in) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WdW'(TimeoutCycles)) begin
            wd_cnt <= wd_cnt + WdW'(1);
        end
    end
`else
    // Watchdog compiled out: TimeoutCycles is a positive count, so this is always 0
    assign wd_timeout = (TimeoutCycles < 0);
`endif

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arb_found) state_nxt = STREAM;
            end
            STREAM: begin
                if (vec_done || wd_timeout) state_nxt = IDLE;
                else if (in_cnt_nxt == CntW'(Chunks)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (vec_done || wd_timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Engine-side mux and pop strobe for the current owner only
    always_comb begin
        eng_valid_out = 1'b0;
        eng_data_out  = '0;
        src_pop_out   = '0;
        busy_out      = (state != IDLE);
        if (state == STREAM) begin
            eng_valid_out = src_valid_in[grant_id_out] && (in_cnt < CntW'(Chunks));
            if (eng_valid_out) begin
                eng_data_out = src_data_in[grant_id_out * ChunkW +: ChunkW];
            end
            src_pop_out[grant_id_out] = eng_valid_out && eng_ready_in;
        end
    end

    // Grant, counters, round-robin pointer, done pulse and sticky error
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            grant_out    <= '0;
            grant_id_out <= '0;
            in_cnt       <= '0;
            out_cnt      <= '0;
            rr_ptr       <= IdW'(NumReq - 1);
            done_out     <= '0;
            err_out      <= 1'b0;
        end else begin
            done_out <= '0;
            if (res_over || wd_timeout || (eng_res_valid_in && state == IDLE)) begin
                err_out <= 1'b1;
            end
            if (state == IDLE) begin
                if (arb_found) begin
                    grant_out    <= NumReq'(1) << arb_id;
                    grant_id_out <= arb_id;
                    in_cnt       <= '0;
                    out_cnt      <= '0;
                end
            end else begin
                in_cnt  <= in_cnt_nxt;
                out_cnt <= out_cnt_nxt;
                if (vec_done || wd_timeout) begin
                    if (vec_done) done_out <= grant_out;
                    rr_ptr       <= grant_id_out;
                    grant_out    <= '0;
                    grant_id_out <= '0;
                end
            end
        end
    end

endmodule
